// File: rtl/clock_time_core.sv
// clock_time_core
// Time-of-day counter with a two-button set-mode controller.
//
// Ports:
//   clk          system clock; every register is clocked here
//   rst          asynchronous, active-low reset; clears all state
//   en_1clk      one-cycle pulse once per second (time base)
//   debclk_10hz  10 Hz square wave; its rising edge is the button sampling strobe
//   btn_mode     raw mode button (active-high, asynchronous, bouncy)
//   btn_up       raw increment button (active-high, asynchronous, bouncy)
//   hour         current hour, 0..MAX_HOUR
//   min          current minute, 0..59
//   sec          current second, 0..59
//   mode         controller state: 0 = RUN, 1 = SET_HOUR, 2 = SET_MIN
//   day_pulse    one-cycle pulse after the RUN-mode midnight rollover
//
// Signalling: there is no valid/ready handshake here. en_1clk and the
// internal press pulses are single-cycle events. Each one is consumed on the
// clock edge where it is high, and the result is visible from the next cycle.

module clock_time_core #(
  parameter int MAX_HOUR = 23
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_1clk,
  input  logic       debclk_10hz,
  input  logic       btn_mode,
  input  logic       btn_up,
  output logic [4:0] hour,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic [1:0] mode,
  output logic       day_pulse
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } mode_t;

  localparam logic [4:0] HOUR_MAX = 5'(MAX_HOUR);
  localparam logic [5:0] MS_MAX   = 6'd59;

  // Button vectors: bit 0 = mode button, bit 1 = up button.
  logic [1:0] btn_raw;
  logic [1:0] sync_a;
  logic [1:0] sync_b;
  logic [1:0] samp_new;
  logic [1:0] samp_old;
  logic [1:0] deb;
  logic [1:0] deb_d;
  logic [1:0] press;

  logic       debclk_d;
  logic       samp;

  mode_t      mode_q, mode_nxt;
  logic [4:0] hour_q, hour_nxt;
  logic [5:0] min_q, min_nxt;
  logic [5:0] sec_q, sec_nxt;
  logic       day_q, day_nxt;

  assign btn_raw = {btn_up, btn_mode};
  assign samp    = debclk_10hz & ~debclk_d;

  // Button conditioning: 2-FF synchronizer, a two-sample history taken on each
  // strobe, and a hysteretic level. The level sets on two high samples and
  // clears on two low samples. Mixed samples hold the level, which suppresses
  // single-sample bounces. The level update on a strobe edge looks at the
  // sample being taken on that same edge (sync_b) together with the previous
  // sample (samp_new).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      debclk_d <= 1'b0;
      sync_a   <= '0;
      sync_b   <= '0;
      samp_new <= '0;
      samp_old <= '0;
      deb      <= '0;
      deb_d    <= '0;
      press    <= '0;
    end else begin
      debclk_d <= debclk_10hz;
      sync_a   <= btn_raw;
      sync_b   <= sync_a;
      if (samp) begin
        samp_new <= sync_b;
        samp_old <= samp_new;
        deb      <= (deb | (sync_b & samp_new)) & ~(~sync_b & ~samp_new);
      end
      deb_d <= deb;
      press <= deb & ~deb_d;
    end
  end

  // State and time registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q <= RUN;
      hour_q <= '0;
      min_q  <= '0;
      sec_q  <= '0;
      day_q  <= 1'b0;
    end else begin
      mode_q <= mode_nxt;
      hour_q <= hour_nxt;
      min_q  <= min_nxt;
      sec_q  <= sec_nxt;
      day_q  <= day_nxt;
    end
  end

  // Next-state and field update. A mode press always takes priority over an
  // up press in the same cycle. In RUN the second tick still applies on the
  // edge where the mode press moves the controller to SET_HOUR.
  always_comb begin
    mode_nxt = mode_q;
    hour_nxt = hour_q;
    min_nxt  = min_q;
    sec_nxt  = sec_q;
    day_nxt  = 1'b0;
    case (mode_q)
      RUN: begin
        if (en_1clk) begin
          if (sec_q == MS_MAX) begin
            sec_nxt = '0;
            if (min_q == MS_MAX) begin
              min_nxt = '0;
              if (hour_q == HOUR_MAX) begin
                hour_nxt = '0;
                day_nxt  = 1'b1;
              end else begin
                hour_nxt = hour_q + 5'd1;
              end
            end else begin
              min_nxt = min_q + 6'd1;
            end
          end else begin
            sec_nxt = sec_q + 6'd1;
          end
        end
        if (press[0]) mode_nxt = SET_HOUR;
      end
      SET_HOUR: begin
        if (press[0]) begin
          mode_nxt = SET_MIN;
        end else if (press[1]) begin
          hour_nxt = (hour_q == HOUR_MAX) ? 5'd0 : hour_q + 5'd1;
        end
      end
      SET_MIN: begin
        if (press[0]) begin
          mode_nxt = RUN;
          sec_nxt  = '0;
        end else if (press[1]) begin
          min_nxt = (min_q == MS_MAX) ? 6'd0 : min_q + 6'd1;
        end
      end
      default: mode_nxt = RUN;
    endcase
  end

  assign hour      = hour_q;
  assign min       = min_q;
  assign sec       = sec_q;
  assign mode      = mode_q;
  assign day_pulse = day_q;

endmodule

// File: tb/tb_clock_time_core.sv
// Testbench for clock_time_core. The bench drives the sampling strobe directly,
// so each button sample is placed on a known cycle. It uses a directed vector
// table, hand-written corner sequences, and a randomized phase. The randomized
// phase is checked against a time-of-day model.

module tb_clock_time_core;

  localparam int OP_TICK = 0;
  localparam int OP_MODE = 1;
  localparam int OP_UP   = 2;

  typedef struct {
    int op;
    int n;
    int h;
    int m;
    int s;
    int md;
  } vec_t;

  // Clock/reset and DUT signals.
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en_1clk = 1'b0;
  logic       debclk_10hz = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_up = 1'b0;
  logic [4:0] hour;
  logic [5:0] min;
  logic [5:0] sec;
  logic [1:0] mode;
  logic       day_pulse;

  int tests = 0;
  int fails = 0;

  // Reference model state.
  int mh = 0, mm = 0, ms = 0, mmode = 0;

  vec_t tbl[20];

  clock_time_core #(.MAX_HOUR(23)) dut (
    .clk(clk),
    .rst(rst),
    .en_1clk(en_1clk),
    .debclk_10hz(debclk_10hz),
    .btn_mode(btn_mode),
    .btn_up(btn_up),
    .hour(hour),
    .min(min),
    .sec(sec),
    .mode(mode),
    .day_pulse(day_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, " hour"}, int'(hour), mh);
    check({tag, " min"},  int'(min),  mm);
    check({tag, " sec"},  int'(sec),  ms);
    check({tag, " mode"}, int'(mode), mmode);
  endtask

  // ---------------- reference model ----------------
  task automatic m_tick(output bit wrap);
    int total;
    wrap = 1'b0;
    if (mmode == 0) begin
      total = (mh * 3600 + mm * 60 + ms + 1) % (24 * 3600);
      wrap  = (total == 0);
      mh    = total / 3600;
      mm    = (total / 60) % 60;
      ms    = total % 60;
    end
  endtask

  task automatic m_mode();
    if (mmode == 2) ms = 0;
    mmode = (mmode + 1) % 3;
  endtask

  task automatic m_up();
    if (mmode == 1) mh = (mh + 1) % 24;
    else if (mmode == 2) mm = (mm + 1) % 60;
  endtask

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    tick();
    tick();
  endtask

  // One strobe rising edge: samp is high for exactly one clk edge.
  task automatic do_samp();
    debclk_10hz = 1'b1;
    tick();
    debclk_10hz = 1'b0;
    tick();
  endtask

  task automatic set_btn(input int which, input logic v);
    if (which == 0) btn_mode = v;
    else btn_up = v;
  endtask

  // Random chatter between strobes, finishing at a stable final level.
  task automatic burst(input int which, input logic final_v);
    for (int i = 0; i < 6; i++) begin
      set_btn(which, logic'($urandom_range(0, 1)));
      tick();
    end
    set_btn(which, final_v);
  endtask

  task automatic ticks(input int n);
    bit w;
    for (int i = 0; i < n; i++) begin
      m_tick(w);
      en_1clk = 1'b1;
      tick();
      en_1clk = 1'b0;
      check("day_pulse", int'(day_pulse), int'(w));
      tick();
      check("day_pulse width", int'(day_pulse), 0);
    end
  endtask

  // Full press and release. The press pulse acts on the tick after the
  // second high sample.
  task automatic press_btn(input int which, input bit bounce);
    if (bounce) burst(which, 1'b1);
    else set_btn(which, 1'b1);
    settle();
    do_samp();
    do_samp();
    tick();
    if (bounce) burst(which, 1'b0);
    else set_btn(which, 1'b0);
    settle();
    do_samp();
    do_samp();
    tick();
    if (which == 0) m_mode();
    else m_up();
  endtask

  task automatic presses(input int which, input int n);
    for (int i = 0; i < n; i++) press_btn(which, 1'b0);
  endtask

  // ---------------- test ----------------
  initial begin
    tbl[0]  = '{OP_TICK, 59,  0,  0, 59, 0};
    tbl[1]  = '{OP_TICK,  1,  0,  1,  0, 0};
    tbl[2]  = '{OP_TICK,  5,  0,  1,  5, 0};
    tbl[3]  = '{OP_UP,    2,  0,  1,  5, 0};
    tbl[4]  = '{OP_MODE,  1,  0,  1,  5, 1};
    tbl[5]  = '{OP_TICK,  3,  0,  1,  5, 1};
    tbl[6]  = '{OP_UP,   23, 23,  1,  5, 1};
    tbl[7]  = '{OP_MODE,  1, 23,  1,  5, 2};
    tbl[8]  = '{OP_TICK,  2, 23,  1,  5, 2};
    tbl[9]  = '{OP_UP,   58, 23, 59,  5, 2};
    tbl[10] = '{OP_MODE,  1, 23, 59,  0, 0};
    tbl[11] = '{OP_TICK, 59, 23, 59, 59, 0};
    tbl[12] = '{OP_TICK,  1,  0,  0,  0, 0};
    tbl[13] = '{OP_MODE,  1,  0,  0,  0, 1};
    tbl[14] = '{OP_UP,   23, 23,  0,  0, 1};
    tbl[15] = '{OP_UP,    1,  0,  0,  0, 1};
    tbl[16] = '{OP_MODE,  1,  0,  0,  0, 2};
    tbl[17] = '{OP_UP,   59,  0, 59,  0, 2};
    tbl[18] = '{OP_UP,    1,  0,  0,  0, 2};
    tbl[19] = '{OP_MODE,  1,  0,  0,  0, 0};

    // Reset state.
    settle();
    check("reset day_pulse", int'(day_pulse), 0);
    check_model("reset");
    rst = 1'b1;
    settle();

    // Directed vector table.
    for (int i = 0; i < 20; i++) begin
      case (tbl[i].op)
        OP_TICK: ticks(tbl[i].n);
        OP_MODE: presses(0, tbl[i].n);
        default: presses(1, tbl[i].n);
      endcase
      check($sformatf("vec%0d hour", i), int'(hour), tbl[i].h);
      check($sformatf("vec%0d min", i),  int'(min),  tbl[i].m);
      check($sformatf("vec%0d sec", i),  int'(sec),  tbl[i].s);
      check($sformatf("vec%0d mode", i), int'(mode), tbl[i].md);
    end

    // A tick in RUN coincides with a mode press: the tick applies and
    // SET_HOUR is entered on the same edge.
    begin
      bit w;
      btn_mode = 1'b1;
      settle();
      do_samp();
      do_samp();
      m_tick(w);
      m_mode();
      en_1clk = 1'b1;
      tick();
      en_1clk = 1'b0;
      check_model("tick+mode");
      btn_mode = 1'b0;
      settle();
      do_samp();
      do_samp();
      tick();
    end

    // Mode and up presses in the same cycle: mode wins, up is dropped.
    btn_mode = 1'b1;
    btn_up = 1'b1;
    settle();
    do_samp();
    do_samp();
    tick();
    m_mode();
    check_model("mode+up");
    btn_mode = 1'b0;
    btn_up = 1'b0;
    settle();
    do_samp();
    do_samp();
    tick();

    // A mode press in SET_MIN with a coincident tick clears sec.
    btn_mode = 1'b1;
    settle();
    do_samp();
    do_samp();
    en_1clk = 1'b1;
    tick();
    en_1clk = 1'b0;
    m_mode();
    check_model("setmin exit+tick");
    btn_mode = 1'b0;
    settle();
    do_samp();
    do_samp();
    tick();

    // Bouncy mode press gives exactly one step. Inside the hold there is a
    // single low sample.
    burst(0, 1'b1);
    settle();
    do_samp();
    burst(0, 1'b1);
    settle();
    do_samp();
    tick();
    m_mode();
    check_model("bounce press");
    do_samp();
    do_samp();
    btn_mode = 1'b0;
    settle();
    do_samp();
    btn_mode = 1'b1;
    settle();
    do_samp();
    do_samp();
    tick();
    check_model("hold no repeat");
    burst(0, 1'b0);
    settle();
    do_samp();
    do_samp();
    tick();
    check_model("bounce release");
    press_btn(0, 1'b0);
    check_model("second press");
    press_btn(0, 1'b0);
    check_model("third press");

    // Reset mid-debounce: the half-taken sample must be forgotten.
    ticks(5);
    check_model("pre-reset");
    btn_mode = 1'b1;
    settle();
    do_samp();
    #2;
    rst = 1'b0;
    #1;
    mh = 0;
    mm = 0;
    ms = 0;
    mmode = 0;
    check_model("async reset");
    tick();
    tick();
    rst = 1'b1;
    settle();
    tick();
    do_samp();
    tick();
    tick();
    check_model("one sample after reset");
    do_samp();
    tick();
    m_mode();
    check_model("two samples after reset");
    btn_mode = 1'b0;
    settle();
    do_samp();
    do_samp();
    tick();

    // Randomized operations checked against the model.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0: ticks($urandom_range(1, 70));
        1: press_btn(0, bit'($urandom_range(0, 1)));
        default: begin
          int n;
          n = $urandom_range(1, 5);
          for (int k = 0; k < n; k++) press_btn(1, bit'($urandom_range(0, 1)));
        end
      endcase
      check_model($sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/clock_time_core.md
# clock_time_core

Time-of-day counter and set-mode controller for the digital clock. Consumes the 1 Hz single-cycle enable and the 10 Hz debounce square wave from the timing-enable generator. Debounces the two user buttons and produces hours/minutes/seconds for the display driver. Every register is clocked by `clk`; no derived clocks are used.

## Interface
Parameters:
- `MAX_HOUR`, default 23: last hour value; hour wraps from `MAX_HOUR` to 0.

Ports:
- `clk`: in, 1 bit. System clock (50 MHz).
- `rst`: in, 1 bit. Reset, asynchronous, active-low.
- `en_1clk`: in, 1 bit. One-`clk`-wide pulse, once per second, synchronous to `clk`.
- `debclk_10hz`: in, 1 bit. 10 Hz square wave, synchronous to `clk`. Used only as a sampling strobe source.
- `btn_mode`: in, 1 bit. Raw mode button, active-high, asynchronous, bouncy.
- `btn_up`: in, 1 bit. Raw increment button, active-high, asynchronous, bouncy.
- `hour`: out, 5 bits. Current hour, 0..`MAX_HOUR`.
- `min`: out, 6 bits. Current minute, 0..59.
- `sec`: out, 6 bits. Current second, 0..59.
- `mode`: out, 2 bits. 0 = RUN, 1 = SET_HOUR, 2 = SET_MIN. 3 is never output.
- `day_pulse`: out, 1 bit. One-cycle pulse on the midnight rollover.

## Operation
- **Reset.** All outputs and internal registers go to 0: `hour`/`min`/`sec` = 0, `mode` = RUN, `day_pulse` = 0, and synchronizers, samples, debounced levels and the strobe delay register are all 0.
- **Strobe.** `debclk_10hz` is registered once; `samp = debclk_10hz & ~debclk_d` gives one pulse per rising edge (every 100 ms).
- **Button conditioning** (identical per button):
  - Each button passes through a 2-FF synchronizer.
  - On each `samp`, shift the synchronized value into a 2-bit sample history.
  - The debounced level becomes 1 when both samples are 1, becomes 0 when both are 0, and otherwise holds.
  - A press pulse (1 cycle) fires on a debounced 0→1 transition. Holding a button produces exactly one press; there is no auto-repeat.
- **FSM.** A `mode` press steps RUN → SET_HOUR → SET_MIN → RUN.
  - On SET_MIN → RUN, clear `sec` to 0.
  - `min` and `hour` keep their values on every mode transition.
- **RUN.**
  - `en_1clk` increments `sec`; 59 wraps to 0 and carries into `min`.
  - `min` 59 wraps to 0 and carries into `hour`.
  - `hour` `MAX_HOUR` wraps to 0.
  - `up` presses are ignored.
- **SET_HOUR.**
  - `up` press: `hour` +1, wrapping `MAX_HOUR` → 0.
  - `en_1clk` is ignored, so time is frozen.
- **SET_MIN.**
  - `up` press: `min` +1, wrapping 59 → 0, with no carry into `hour`.
  - `en_1clk` is ignored.
- **`day_pulse`.** Asserts for one cycle only when RUN rolls `MAX_HOUR`:59:59 → 0:00:00. It never asserts from a set-mode wrap.
- **Simultaneous events.**
  - `en_1clk` together with a `mode` press in RUN: apply the tick using RUN rules, and enter SET_HOUR on the same edge.
  - `mode` and `up` presses in the same cycle: the mode press wins; the `up` press is dropped.
  - A mode press in SET_MIN with `en_1clk` in the same cycle: `sec` = 0.
- **Arithmetic.** Compare fields for equality against 59 / `MAX_HOUR` before incrementing. Never let a field exceed its maximum.

## Timing
- A tick or press sampled at edge N updates `hour`/`min`/`sec`/`mode` at edge N (registered), so values are visible from cycle N+1. `day_pulse` is high in cycle N+1 only.
- Button latency, from the synchronized level settling high to the press pulse:
  - the first `samp` after sync (2 `clk` edges) loads sample 1;
  - the next `samp` loads sample 2;
  - the debounced level sets on that edge, and the press pulse is registered one cycle later.
  - Worst case is about 200 ms + 4 cycles; minimum is about 100 ms + 4 cycles.
- Bounces shorter than one sample spacing (100 ms) that do not appear in two consecutive samples produce no press.
- Release needs two consecutive low samples before a new press can be generated.
- Reset asserted mid-operation immediately clears all state, including a half-debounced press; no press pulse may follow reset release unless the button is held through two new samples.

## Test plan
- Reset, then 59 `en_1clk` pulses → `sec` = 59 and `min` = 0; one more pulse → `sec` = 0 and `min` = 1; `day_pulse` stays 0 throughout.
- Preload via set mode to 23:59, return to RUN (`sec` = 0), then 59 ticks to 23:59:59; next tick → 00:00:00 with `day_pulse` high for exactly 1 cycle.
- `btn_mode` held high with 30 ms bounce bursts on its edges → exactly one press, and `mode` goes 0 → 1. Two more clean presses → 2, then 0, with `sec` cleared to 0.
- SET_HOUR at `hour` = 23, one `up` press → `hour` = 0 and `min` unchanged. SET_MIN at `min` = 59, one `up` press → `min` = 0 and `hour` unchanged. `en_1clk` pulses during set modes leave `sec` unchanged.
- RUN with `en_1clk` coincident with a `mode` press pulse (force `samp` alignment) → `sec` increments and `mode` = 1 on the same edge. `up` held in RUN → no field change.
- Drop `rst` mid-debounce (one high sample taken), release it with the button held high → `mode` stays 0 until two fresh high samples, then `mode` = 1.
